// File: rtl/accum_shift_pkg.sv
// accum_shift_pkg
// Shared types for the accumulator shift unit: operation codes, FSM states
// and small helpers used to size the shift-count port and classify opcodes.
package accum_shift_pkg;

  // Operation codes as seen on the op port; 3'b111 is reserved and acts as HOLD
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Count port must be able to express a full-width shift, hence N+1 values
  function automatic int shift_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic is_shift_op(input op_e o);
    return o inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
  endfunction

endpackage

// File: rtl/accum_shift_step.sv
// accum_shift_step
// Combinational single-bit shift/rotate step.
// Ports:
//   value      - current register contents
//   op         - operation to apply (non-shift codes pass value through)
//   fill       - bit shifted in for SLL/SRL
//   next_value - value after one step
//   carry_out  - bit leaving the register (the wrapped bit for rotates)
module accum_shift_step
  import accum_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  op_e          op,
  input  logic         fill,
  output logic [N-1:0] next_value,
  output logic         carry_out
);

  always_comb begin
    next_value = value;
    carry_out  = 1'b0;
    case (op)
      OP_SLL: begin
        next_value = {value[N-2:0], fill};
        carry_out  = value[N-1];
      end
      OP_SRL: begin
        next_value = {fill, value[N-1:1]};
        carry_out  = value[0];
      end
      // Arithmetic right shift replicates the sign bit
      OP_SRA: begin
        next_value = {value[N-1], value[N-1:1]};
        carry_out  = value[0];
      end
      OP_ROL: begin
        next_value = {value[N-2:0], value[N-1]};
        carry_out  = value[N-1];
      end
      OP_ROR: begin
        next_value = {value[0], value[N-1:1]};
        carry_out  = value[0];
      end
      default: begin
        next_value = value;
        carry_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/accum_shift_unit.sv
// accum_shift_unit
// Multi-cycle accumulator shifter: one bit per clock, start/busy/done handshake.
// Ports:
//   clk        - rising-edge clock
//   clr        - asynchronous active-low reset (Reg_out=0, carry=0, IDLE)
//   set        - synchronous active-low preset (Reg_out=all ones, carry=0, IDLE)
//   start      - operation request, accepted in IDLE or DONE
//   op         - operation code (see accum_shift_pkg::op_e)
//   num_shift  - shift count, 0..N and beyond performed literally
//   Ls, Rs     - fill bits for SLL / SRL
//   Reg_in     - parallel load data
//   Reg_out    - accumulator contents
//   carry      - last bit shifted or rotated out
//   zero       - Reg_out == 0
//   busy       - high while shifting
//   done       - one-cycle completion pulse
module accum_shift_unit
  import accum_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = shift_width(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [SW-1:0] num_shift,
  input  logic          Ls,
  input  logic          Rs,
  input  logic [N-1:0]  Reg_in,
  output logic [N-1:0]  Reg_out,
  output logic          carry,
  output logic          zero,
  output logic          busy,
  output logic          done
);

  state_e        state, next_state;
  logic [SW-1:0] count;
  op_e           op_q;
  logic          fill_q;
  op_e           op_in;
  logic          accept;
  logic          shift_req;
  logic          fill_in;
  logic [N-1:0]  step_value;
  logic          step_carry;

  assign op_in     = op_e'(op);
  assign accept    = start && (state != ST_SHIFT);
  // Zero-count shifts complete like HOLD and never enter SHIFT
  assign shift_req = is_shift_op(op_in) && (num_shift != '0);
  assign fill_in   = (op_in == OP_SLL) ? Ls : (op_in == OP_SRL) ? Rs : 1'b0;

  accum_shift_step #(.N(N)) u_step (
    .value      (Reg_out),
    .op         (op_q),
    .fill       (fill_q),
    .next_value (step_value),
    .carry_out  (step_carry)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= next_state;
  end

  // A start seen in DONE is accepted directly, so back-to-back ops have no gap
  always_comb begin
    next_state = state;
    if (!set) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          next_state = ST_IDLE;
          if (accept) next_state = shift_req ? ST_SHIFT : ST_DONE;
        end
        ST_SHIFT: if (count == SW'(1)) next_state = ST_DONE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath: op and fill are latched on accept so the inputs may change mid-shift
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      Reg_out <= '0;
      carry   <= 1'b0;
      count   <= '0;
      op_q    <= OP_HOLD;
      fill_q  <= 1'b0;
    end else if (!set) begin
      Reg_out <= '1;
      carry   <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      if (op_in == OP_LOAD) begin
        Reg_out <= Reg_in;
        carry   <= 1'b0;
      end else if (shift_req) begin
        op_q   <= op_in;
        fill_q <= fill_in;
        count  <= num_shift;
      end
    end else if (state == ST_SHIFT) begin
      Reg_out <= step_value;
      carry   <= step_carry;
      count   <= count - SW'(1);
    end
  end

  assign zero = (Reg_out == '0);
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_accum_shift_unit.sv
// tb_accum_shift_unit
// Directed bench for accum_shift_unit (N=8) with hand-computed expectations.
module tb_accum_shift_unit;

  logic       clk = 1'b0;
  logic       clr, set, start, Ls, Rs;
  logic [2:0] op;
  logic [3:0] num_shift;
  logic [7:0] Reg_in, Reg_out;
  logic       carry, zero, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  accum_shift_unit #(.N(8)) dut (
    .clk(clk), .clr(clr), .set(set), .start(start), .op(op),
    .num_shift(num_shift), .Ls(Ls), .Rs(Rs), .Reg_in(Reg_in),
    .Reg_out(Reg_out), .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge, then wait (bounded) for done
  task automatic issue(input logic [2:0] o, input logic [3:0] k, input logic fill,
                       input logic [7:0] din, output int edges, output int busy_cycles);
    op = o; num_shift = k; Ls = fill; Rs = fill; Reg_in = din; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; set = 1'b1; start = 1'b0; op = 3'b000; num_shift = 4'd0;
    Ls = 1'b0; Rs = 1'b0; Reg_in = 8'h00;
    #2;
    n_checks++; if (Reg_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_value: got %h expected 00", Reg_out); end
    n_checks++; if ({carry, zero, busy, done} !== 4'b0100) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0100", {carry, zero, busy, done}); end
    @(negedge clk);
    clr = 1'b1;
    set = 1'b0;
    tick();
    set = 1'b1;
    n_checks++; if (Reg_out !== 8'hFF || zero !== 1'b0) begin n_fail++; $display("[TB] FAIL set_value: got %h zero %b expected FF zero 0", Reg_out, zero); end
  endtask

  task automatic test_load_sll();
    int e, b;
    issue(3'b001, 4'd0, 1'b0, 8'hA5, e, b);
    n_checks++; if (Reg_out !== 8'hA5 || done !== 1'b1 || e != 0) begin n_fail++; $display("[TB] FAIL load: got %h done %b edges %0d expected A5 1 0", Reg_out, done, e); end
    issue(3'b010, 4'd3, 1'b1, 8'h00, e, b);
    // Three step edges follow the accept edge; busy is seen in three samples
    n_checks++; if (e != 3 || b != 3) begin n_fail++; $display("[TB] FAIL sll_timing: got edges %0d busy %0d expected 3 3", e, b); end
    n_checks++; if (Reg_out !== 8'h2F || carry !== 1'b1) begin n_fail++; $display("[TB] FAIL sll_value: got %h c%b expected 2F c1", Reg_out, carry); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL done_pulse: got done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_shifts();
    int e, b;
    issue(3'b001, 4'd0, 1'b0, 8'h90, e, b);
    issue(3'b100, 4'd3, 1'b0, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'hF2 || carry !== 1'b0 || e != 3) begin n_fail++; $display("[TB] FAIL sra: got %h c%b edges %0d expected F2 c0 3", Reg_out, carry, e); end
    issue(3'b001, 4'd0, 1'b0, 8'h81, e, b);
    issue(3'b011, 4'd8, 1'b0, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'h00 || carry !== 1'b1 || zero !== 1'b1 || e != 8) begin n_fail++; $display("[TB] FAIL srl8: got %h c%b z%b edges %0d expected 00 c1 z1 8", Reg_out, carry, zero, e); end
    issue(3'b001, 4'd0, 1'b0, 8'h01, e, b);
    issue(3'b110, 4'd1, 1'b0, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'h80 || carry !== 1'b1 || e != 1) begin n_fail++; $display("[TB] FAIL ror1: got %h c%b edges %0d expected 80 c1 1", Reg_out, carry, e); end
    // Zero count completes immediately and keeps both value and carry
    issue(3'b010, 4'd0, 1'b1, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'h80 || carry !== 1'b1 || done !== 1'b1 || e != 0) begin n_fail++; $display("[TB] FAIL count0: got %h c%b done %b edges %0d expected 80 c1 1 0", Reg_out, carry, done, e); end
    issue(3'b001, 4'd0, 1'b0, 8'h3C, e, b);
    issue(3'b101, 4'd8, 1'b0, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'h3C || carry !== 1'b0 || e != 8) begin n_fail++; $display("[TB] FAIL rol8: got %h c%b edges %0d expected 3C c0 8", Reg_out, carry, e); end
  endtask

  task automatic test_hold_reserved();
    int e, b;
    issue(3'b001, 4'd0, 1'b0, 8'h77, e, b);
    issue(3'b111, 4'd5, 1'b1, 8'h11, e, b);
    n_checks++; if (Reg_out !== 8'h77 || done !== 1'b1 || e != 0) begin n_fail++; $display("[TB] FAIL reserved: got %h done %b edges %0d expected 77 1 0", Reg_out, done, e); end
    issue(3'b000, 4'd2, 1'b1, 8'h22, e, b);
    n_checks++; if (Reg_out !== 8'h77 || done !== 1'b1 || e != 0) begin n_fail++; $display("[TB] FAIL hold: got %h done %b edges %0d expected 77 1 0", Reg_out, done, e); end
  endtask

  task automatic test_busy_ignore();
    int e, b;
    int cyc;
    issue(3'b001, 4'd0, 1'b0, 8'h0F, e, b);
    op = 3'b010; num_shift = 4'd4; Ls = 1'b0; start = 1'b1;
    tick();
    // Request a LOAD of FF while shifting; it must be dropped
    op = 3'b001; Reg_in = 8'hFF;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == 2) start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (Reg_out !== 8'hF0 || cyc != 4) begin n_fail++; $display("[TB] FAIL busy_ignore: got %h edges %0d expected F0 4", Reg_out, cyc); end
    tick(); tick();
    n_checks++; if (Reg_out !== 8'hF0 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL no_queue: got %h done %b busy %b expected F0 0 0", Reg_out, done, busy); end
  endtask

  task automatic test_back_to_back();
    int e, b;
    int cyc;
    issue(3'b001, 4'd0, 1'b0, 8'h03, e, b);
    issue(3'b011, 4'd1, 1'b1, 8'h00, e, b);
    n_checks++; if (Reg_out !== 8'h81 || carry !== 1'b1 || done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first: got %h c%b done %b expected 81 c1 1", Reg_out, carry, done); end
    op = 3'b101; num_shift = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_nogap: got busy %b done %b expected 1 0", busy, done); end
    cyc = 0;
    while (!done && cyc < 40) begin tick(); cyc++; end
    n_checks++; if (Reg_out !== 8'h06 || carry !== 1'b0 || cyc != 2) begin n_fail++; $display("[TB] FAIL b2b_second: got %h c%b edges %0d expected 06 c0 2", Reg_out, carry, cyc); end
  endtask

  task automatic test_abort();
    int e, b;
    int pulses;
    issue(3'b001, 4'd0, 1'b0, 8'hA5, e, b);
    op = 3'b010; num_shift = 4'd5; Ls = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Third shift cycle: preset wins at the next edge
    set = 1'b0;
    tick();
    set = 1'b1;
    n_checks++; if (Reg_out !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_set: got %h busy %b done %b c%b expected FF 0 0 c0", Reg_out, busy, done, carry); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) pulses++; end
    n_checks++; if (pulses != 0 || Reg_out !== 8'hFF) begin n_fail++; $display("[TB] FAIL abort_set_nodone: got pulses %0d value %h expected 0 FF", pulses, Reg_out); end

    issue(3'b001, 4'd0, 1'b0, 8'hA5, e, b);
    op = 3'b010; num_shift = 4'd5; Ls = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Asynchronous reset mid-cycle, well away from any edge
    #2;
    clr = 1'b0;
    #1;
    n_checks++; if (Reg_out !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_clr: got %h c%b z%b busy %b expected 00 c0 z1 0", Reg_out, carry, zero, busy); end
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) pulses++; end
    n_checks++; if (pulses != 0 || Reg_out !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_clr_nodone: got pulses %0d value %h expected 0 00", pulses, Reg_out); end
  endtask

  initial begin
    test_reset();
    test_load_sll();
    test_shifts();
    test_hold_reserved();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
